// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    localparam int REG_IDX_W = 5;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX load and the ID source operands.
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 rs1_used_id,
    input  logic                 rs2_used_id,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = rs1_used_id && (rs1_id == ex_rd);
    assign rs2_hit = rs2_used_id && (rs2_id == ex_rd);

    // x0 is hardwired zero, so a load to it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes, memory wait, debug halt and
// stall/flush performance counters for the 5-stage core.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 rs1_used_id,
    input  logic                 rs2_used_id,
    input  logic                 ex_mem_read,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 branch_taken_ex,
    input  logic [XLEN-1:0]      branch_target_ex,
    input  logic                 mem_req,
    input  logic                 mem_ack,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 ifid_flush,
    output logic                 idex_en,
    output logic                 idex_flush,
    output logic                 exmem_en,
    output logic                 pc_redirect_valid,
    output logic [XLEN-1:0]      pc_redirect,
    output logic                 halted,
    output logic                 timeout_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_ONE  = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_nxt;
    logic              load_use;
    logic              eval_run;
    logic              flush_inc;
    logic              timeout_set;

    pipe_hazard_ctrl_hazard_detect u_hazard (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    always_comb begin
        state_nxt         = state;
        wait_nxt          = wait_cnt;
        eval_run          = 1'b0;
        flush_inc         = 1'b0;
        timeout_set       = 1'b0;
        pc_en             = 1'b0;
        ifid_en           = 1'b0;
        ifid_flush        = 1'b0;
        idex_en           = 1'b0;
        idex_flush        = 1'b0;
        exmem_en          = 1'b0;
        pc_redirect_valid = 1'b0;
        pc_redirect       = '0;
        halted            = 1'b0;

        unique case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_ONE;
                end else begin
                    eval_run = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    eval_run = 1'b1;
                end else if (wait_cnt >= WAIT_LAST) begin
                    timeout_set = 1'b1;
                    state_nxt   = HALTED;
                    wait_nxt    = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_ONE;
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume && !timeout_err) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        // Normal issue cycle; the ack cycle of a memory wait lands here too
        if (eval_run) begin
            state_nxt = RUN;
            wait_nxt  = '0;
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            idex_en   = 1'b1;
            exmem_en  = 1'b1;
            if (branch_taken_ex) begin
                pc_redirect_valid = 1'b1;
                pc_redirect       = branch_target_ex;
                ifid_flush        = 1'b1;
                idex_flush        = 1'b1;
                flush_inc         = 1'b1;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (halt_req) begin
                state_nxt = HALTED;
            end
        end

        if (!rst) begin
            pc_en             = 1'b0;
            ifid_en           = 1'b0;
            ifid_flush        = 1'b0;
            idex_en           = 1'b0;
            idex_flush        = 1'b0;
            exmem_en          = 1'b0;
            pc_redirect_valid = 1'b0;
            pc_redirect       = '0;
            halted            = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
            if (!pc_en && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed vector bench for pipe_hazard_ctrl (small counters and timeout).
module tb_pipe_hazard_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int MTO   = 4;

    logic            clk;
    logic            rst;
    logic [4:0]      rs1_id, rs2_id, ex_rd;
    logic            rs1_used_id, rs2_used_id, ex_mem_read;
    logic            branch_taken_ex;
    logic [XLEN-1:0] branch_target_ex;
    logic            mem_req, mem_ack, halt_req, resume;
    logic            pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic            pc_redirect_valid, halted, timeout_err;
    logic [XLEN-1:0] pc_redirect;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_run;
    int n_fail;
    int exp_stall;
    int exp_flush;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        mrd;
        logic [4:0]  rd;
        logic        br;
        logic [31:0] tgt;
        logic        mreq;
        logic        mack;
        logic        e_pc;
        logic        e_ifid;
        logic        e_ifid_fl;
        logic        e_idex;
        logic        e_idex_fl;
        logic        e_exmem;
        logic        e_rv;
        logic [31:0] e_redir;
    } vec_t;

    vec_t vt[10];

    pipe_hazard_ctrl #(
        .XLEN        (XLEN),
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MTO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rs1_id            (rs1_id),
        .rs2_id            (rs2_id),
        .rs1_used_id       (rs1_used_id),
        .rs2_used_id       (rs2_used_id),
        .ex_mem_read       (ex_mem_read),
        .ex_rd             (ex_rd),
        .branch_taken_ex   (branch_taken_ex),
        .branch_target_ex  (branch_target_ex),
        .mem_req           (mem_req),
        .mem_ack           (mem_ack),
        .halt_req          (halt_req),
        .resume            (resume),
        .pc_en             (pc_en),
        .ifid_en           (ifid_en),
        .ifid_flush        (ifid_flush),
        .idex_en           (idex_en),
        .idex_flush        (idex_flush),
        .exmem_en          (exmem_en),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect       (pc_redirect),
        .halted            (halted),
        .timeout_err       (timeout_err),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rs1_id = '0; rs2_id = '0; ex_rd = '0;
        rs1_used_id = 0; rs2_used_id = 0; ex_mem_read = 0;
        branch_taken_ex = 0; branch_target_ex = '0;
        mem_req = 0; mem_ack = 0; halt_req = 0; resume = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_en(input string nm, input logic [3:0] exp);
        chk({nm, " enables"}, {28'd0, pc_en, ifid_en, idex_en, exmem_en},
            {28'd0, exp});
    endtask

    // Async reset away from any clock edge, then release on a negedge
    task automatic do_reset(input string nm);
        idle();
        rst = 1'b0;
        #1;
        chk({nm, " rst halted"}, {31'd0, halted}, 32'd0);
        chk({nm, " rst stall_cnt"}, {28'd0, stall_cnt}, 32'd0);
        chk({nm, " rst flush_cnt"}, {28'd0, flush_cnt}, 32'd0);
        chk({nm, " rst timeout"}, {31'd0, timeout_err}, 32'd0);
        chk_en({nm, " rst"}, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        exp_stall = 0;
        exp_flush = 0;

        //        rs1 rs2 u1 u2 mrd rd br tgt            mreq mack | pc ifid ifl idex ifl exm rv redir
        vt[0] = '{0,  0,  0, 0, 0,  0, 0, 32'h0,         0, 0,  1, 1, 0, 1, 0, 1, 0, 32'h0};
        vt[1] = '{5,  7,  1, 1, 1,  5, 0, 32'h0,         0, 0,  0, 0, 0, 1, 1, 1, 0, 32'h0};
        vt[2] = '{7,  5,  1, 1, 1,  5, 0, 32'h0,         0, 0,  0, 0, 0, 1, 1, 1, 0, 32'h0};
        vt[3] = '{5,  7,  0, 1, 1,  5, 0, 32'h0,         0, 0,  1, 1, 0, 1, 0, 1, 0, 32'h0};
        vt[4] = '{0,  0,  1, 1, 1,  0, 0, 32'h0,         0, 0,  1, 1, 0, 1, 0, 1, 0, 32'h0};
        vt[5] = '{5,  5,  1, 1, 0,  5, 0, 32'h0,         0, 0,  1, 1, 0, 1, 0, 1, 0, 32'h0};
        vt[6] = '{5,  7,  1, 1, 1,  5, 1, 32'h100,       0, 0,  1, 1, 1, 1, 1, 1, 1, 32'h100};
        vt[7] = '{1,  2,  1, 1, 0,  3, 1, 32'hDEADBEEC,  0, 0,  1, 1, 1, 1, 1, 1, 1, 32'hDEADBEEC};
        vt[8] = '{0,  0,  0, 0, 0,  0, 0, 32'h0,         1, 1,  1, 1, 0, 1, 0, 1, 0, 32'h0};
        vt[9] = '{0,  0,  0, 0, 0,  0, 0, 32'hFFFFFFFF,  0, 0,  1, 1, 0, 1, 0, 1, 0, 32'h0};

        idle();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("por enables", {28'd0, pc_en, ifid_en, idex_en, exmem_en}, 32'd0);
        chk("por flushes", {30'd0, ifid_flush, idex_flush}, 32'd0);
        chk("por redirect", {31'd0, pc_redirect_valid}, 32'd0);
        chk("por halted", {31'd0, halted}, 32'd0);
        chk("por stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("por flush_cnt", {28'd0, flush_cnt}, 32'd0);
        chk("por timeout", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // Single-cycle RUN behaviour from the vector table
        for (int i = 0; i < 10; i++) begin
            rs1_id = vt[i].rs1; rs2_id = vt[i].rs2;
            rs1_used_id = vt[i].u1; rs2_used_id = vt[i].u2;
            ex_mem_read = vt[i].mrd; ex_rd = vt[i].rd;
            branch_taken_ex = vt[i].br; branch_target_ex = vt[i].tgt;
            mem_req = vt[i].mreq; mem_ack = vt[i].mack;
            @(negedge clk);
            chk($sformatf("v%0d pc_en", i), {31'd0, pc_en}, {31'd0, vt[i].e_pc});
            chk($sformatf("v%0d ifid_en", i), {31'd0, ifid_en}, {31'd0, vt[i].e_ifid});
            chk($sformatf("v%0d ifid_flush", i), {31'd0, ifid_flush}, {31'd0, vt[i].e_ifid_fl});
            chk($sformatf("v%0d idex_en", i), {31'd0, idex_en}, {31'd0, vt[i].e_idex});
            chk($sformatf("v%0d idex_flush", i), {31'd0, idex_flush}, {31'd0, vt[i].e_idex_fl});
            chk($sformatf("v%0d exmem_en", i), {31'd0, exmem_en}, {31'd0, vt[i].e_exmem});
            chk($sformatf("v%0d redir_valid", i), {31'd0, pc_redirect_valid}, {31'd0, vt[i].e_rv});
            chk($sformatf("v%0d redir", i), pc_redirect, vt[i].e_redir);
            if (!vt[i].e_pc) exp_stall++;
            if (vt[i].e_rv) exp_flush++;
            next_cycle();
        end
        idle();
        chk("table stall_cnt", {28'd0, stall_cnt}, exp_stall);
        chk("table flush_cnt", {28'd0, flush_cnt}, exp_flush);

        // Memory wait: ack arrives on the fourth cycle of the access
        do_reset("mw");
        mem_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_en($sformatf("mw c%0d", c), 4'b0000);
            chk($sformatf("mw c%0d flush", c), {30'd0, ifid_flush, idex_flush}, 32'd0);
            next_cycle();
        end
        mem_ack = 1'b1;
        @(negedge clk);
        chk_en("mw ack", 4'b1111);
        next_cycle();
        idle();
        @(negedge clk);
        chk_en("mw after", 4'b1111);
        chk("mw stall_cnt", {28'd0, stall_cnt}, 32'd3);
        next_cycle();

        // Timeout: no ack, sticky error, resume ignored, saturating stall_cnt
        do_reset("to");
        mem_req = 1'b1;
        for (int c = 0; c < MTO; c++) begin
            @(negedge clk);
            chk_en($sformatf("to c%0d", c), 4'b0000);
            chk($sformatf("to c%0d err", c), {31'd0, timeout_err}, 32'd0);
            next_cycle();
        end
        mem_req = 1'b0;
        @(negedge clk);
        chk("to err", {31'd0, timeout_err}, 32'd1);
        chk("to halted", {31'd0, halted}, 32'd1);
        next_cycle();
        resume = 1'b1;
        next_cycle();
        resume = 1'b0;
        @(negedge clk);
        chk("to resume ignored", {31'd0, halted}, 32'd1);
        chk_en("to halted", 4'b0000);
        repeat (14) next_cycle();
        chk("to stall_cnt sat", {28'd0, stall_cnt}, 32'd15);
        do_reset("to clr");

        // Halt, ignored branch, resume, then async reset while halted
        halt_req = 1'b1;
        @(negedge clk);
        chk_en("hr req", 4'b1111);
        chk("hr req halted", {31'd0, halted}, 32'd0);
        next_cycle();
        halt_req = 1'b0;
        branch_taken_ex = 1'b1;
        branch_target_ex = 32'h200;
        @(negedge clk);
        chk("hr halted", {31'd0, halted}, 32'd1);
        chk_en("hr halted", 4'b0000);
        chk("hr br ignored", {31'd0, pc_redirect_valid}, 32'd0);
        next_cycle();
        chk("hr flush_cnt", {28'd0, flush_cnt}, 32'd0);
        branch_taken_ex = 1'b0;
        resume = 1'b1;
        next_cycle();
        resume = 1'b0;
        @(negedge clk);
        chk("hr resumed", {31'd0, halted}, 32'd0);
        chk_en("hr resumed", 4'b1111);
        halt_req = 1'b1;
        next_cycle();
        halt_req = 1'b0;
        next_cycle();
        chk("hr rehalt", {31'd0, halted}, 32'd1);
        #2;
        do_reset("hr mid");
        resume = 1'b1;
        @(negedge clk);
        chk_en("hr run", 4'b1111);
        chk("hr run halted", {31'd0, halted}, 32'd0);
        next_cycle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32 core; drives enable/flush of PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards, redirects and flushes on taken branch/jump, freezes the pipe on data-memory wait, and supports debug halt/resume.
- Keeps stall/flush performance counters and a memory-timeout error flag.

Parameters:
- XLEN, 32, PC/target width
- CNT_W, 16, width of performance counters (saturating)
- MEM_TIMEOUT, 64, max MEM_WAIT cycles before timeout_err

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- rs1_id  in  5  rs1 field of instruction in ID
- rs2_id  in  5  rs2 field of instruction in ID
- rs1_used_id  in  1  ID instruction reads rs1
- rs2_used_id  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- branch_taken_ex  in  1  EX resolves taken branch/jump
- branch_target_ex  in  XLEN  redirect target
- mem_req  in  1  MEM stage issues data access
- mem_ack  in  1  data memory completes access
- halt_req  in  1  debug halt request (level)
- resume  in  1  debug resume pulse
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID load NOP
- idex_en  out  1  ID/EX register load enable
- idex_flush  out  1  ID/EX load bubble (control signals zero)
- exmem_en  out  1  EX/MEM and later registers enable
- pc_redirect_valid  out  1  PC mux select redirect
- pc_redirect  out  XLEN  redirect address
- halted  out  1  core halted
- timeout_err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  number of redirects taken

Behaviour:
- States: RUN, MEM_WAIT, HALTED. State, counters and timeout_err registered; enables/flushes are combinational from state + current inputs (same-cycle response required for load-use).
- Reset (rst low, async): state RUN, stall_cnt=0, flush_cnt=0, timeout_err=0, wait counter 0. While rst low all enables 0, flushes 0, pc_redirect_valid 0, halted 0.
- Load-use hazard: ex_mem_read and ex_rd!=0 and ((rs1_used_id and rs1_id==ex_rd) or (rs2_used_id and rs2_id==ex_rd)). x0 never hazards.
- RUN, priority highest first:
  1. mem_req and not mem_ack: all enables 0, no flush; next MEM_WAIT, wait counter=1.
  2. branch_taken_ex: pc_redirect_valid=1, pc_redirect=branch_target_ex, all enables 1, ifid_flush=1, idex_flush=1 (two bubbles); flush_cnt+1. Suppresses any simultaneous load-use stall.
  3. load-use: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=1 (exactly one bubble).
  4. halt_req: finish current cycle normally (all enables 1), next HALTED.
  5. else all enables 1, no flush.
- mem_req with mem_ack same cycle: no stall, handled as normal RUN cycle.
- MEM_WAIT: all enables 0; wait counter increments. mem_ack=1 -> that cycle behaves as RUN (rules 2-5 evaluated, rule 1 skipped), next RUN unless rule 4 fires. Counter reaching MEM_TIMEOUT without ack -> timeout_err=1 (sticky until reset), next HALTED.
- HALTED: halted=1, all enables 0; branch/load-use/mem inputs ignored. resume and not timeout_err -> next RUN. resume ignored while timeout_err=1. halt_req in HALTED keeps HALTED.
- stall_cnt increments every cycle pc_en=0 while rst high (including HALTED); both counters saturate at all-ones.
- pc_redirect = 0 whenever pc_redirect_valid=0.

Decomposition:
- Shared package: state enum (RUN, MEM_WAIT, HALTED), register-index width constant (5), NOP instruction constant 32'h00000013 used by IF/ID flush.
- One sub-module natural: hazard_detect (pure combinational load-use compare); FSM and counters in top.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x7 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1.
- x0 load: ex_mem_read=1, ex_rd=0, rs1_id=0 -> no stall, all enables 1.
- Branch + load-use same cycle: branch_taken_ex=1, target 0x0000_0100, hazard true -> pc_redirect_valid=1, pc_redirect=0x100, pc_en=1, ifid_flush=idex_flush=1, flush_cnt=1.
- Memory wait: mem_req=1, ack after 3 cycles -> 3 cycles enables 0, ack cycle enables 1, state RUN; stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, no ack -> timeout_err=1 after 4 wait cycles, halted=1; resume ignored; rst low clears both.
- Halt/resume with async reset mid-HALTED: halt_req -> halted=1 next cycle; rst low -> halted=0, counters 0 immediately; resume after reset irrelevant, RUN.
